// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the 32-bit instruction memory.
// It receives a byte stream over a valid/ready handshake. The first four bytes
// are a little-endian word count N, followed by 4*N little-endian image bytes.
// Each assembled word is written to consecutive word-aligned byte addresses.
// The CPU is held in reset until the whole image has been written.
//
// Ports:
//   clock       rising-edge system clock
//   reset       asynchronous active-high reset
//   start       one-cycle load request, honoured in IDLE/DONE/ERROR
//   byte_valid  byte_data is valid this cycle
//   byte_data   stream byte
//   byte_ready  loader accepts a byte this cycle (high in LEN and DATA)
//   we          one-cycle instruction memory write strobe
//   waddr       byte address of the write (word aligned)
//   wdata       assembled instruction word
//   cpu_hold    keeps the CPU in reset while high
//   done        level: image loaded successfully
//   error       level: image length exceeded DEPTH
module imem_loader #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2048
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             we,
  output logic [WIDTH-1:0] waddr,
  output logic [WIDTH-1:0] wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  localparam int WCW = $clog2(DEPTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_DONE,
    S_ERROR
  } state_e;

  state_e           state_q;
  logic [1:0]       bcnt_q;
  logic [WCW-1:0]   wcnt_q;
  logic [WIDTH-1:0] len_q;
  logic [WIDTH-1:0] word_q;
  logic             byte_ready_q;
  logic             we_q;
  logic [WIDTH-1:0] waddr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             cpu_hold_q;
  logic             done_q;
  logic             error_q;

  logic             accept;
  logic             restart;
  logic [WIDTH-1:0] len_d;
  logic [WIDTH-1:0] word_d;
  logic [WCW-1:0]   wcnt_d;

  assign accept  = byte_valid & byte_ready_q;
  assign restart = start & ((state_q == S_IDLE) | (state_q == S_DONE) |
                            (state_q == S_ERROR));
  // Bytes shift in from the top so the first byte ends up in bits [7:0].
  assign len_d   = {byte_data, len_q[WIDTH-1:8]};
  assign word_d  = {byte_data, word_q[WIDTH-1:8]};
  assign wcnt_d  = wcnt_q + WCW'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      bcnt_q       <= '0;
      wcnt_q       <= '0;
      len_q        <= '0;
      word_q       <= '0;
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (restart) begin
        state_q      <= S_LEN;
        bcnt_q       <= '0;
        wcnt_q       <= '0;
        byte_ready_q <= 1'b1;
        cpu_hold_q   <= 1'b1;
        done_q       <= 1'b0;
        error_q      <= 1'b0;
      end else begin
        case (state_q)
          S_LEN: begin
            if (accept) begin
              len_q  <= len_d;
              bcnt_q <= bcnt_q + 2'd1;
              if (bcnt_q == 2'd3) begin
                if (len_d == '0) begin
                  state_q      <= S_DONE;
                  byte_ready_q <= 1'b0;
                end else if (len_d > WIDTH'(DEPTH)) begin
                  state_q      <= S_ERROR;
                  byte_ready_q <= 1'b0;
                end else begin
                  state_q <= S_DATA;
                end
              end
            end
          end
          S_DATA: begin
            if (accept) begin
              word_q <= word_d;
              bcnt_q <= bcnt_q + 2'd1;
              if (bcnt_q == 2'd3) begin
                // Strobe is registered here, so it appears the cycle after
                // the last byte of the word is accepted.
                we_q    <= 1'b1;
                waddr_q <= WIDTH'(wcnt_q) << 2;
                wdata_q <= word_d;
                wcnt_q  <= wcnt_d;
                if (WIDTH'(wcnt_d) == len_q) begin
                  state_q      <= S_DONE;
                  byte_ready_q <= 1'b0;
                end
              end
            end
          end
          // done/cpu_hold follow one cycle after entering DONE, so they
          // never overlap the final write strobe.
          S_DONE: begin
            done_q     <= 1'b1;
            cpu_hold_q <= 1'b0;
          end
          S_ERROR: begin
            error_q    <= 1'b1;
            cpu_hold_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign byte_ready = byte_ready_q;
  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  imem_loader #(.WIDTH(32), .DEPTH(2048)) dut (
    .clock(clock), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;
  logic [63:0] exp_q[$];   // {waddr, wdata}
  logic        prev_we = 1'b0;
  logic [31:0] last_waddr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard monitor: every write strobe is matched against the queue.
  always @(negedge clock) begin
    if (!reset) begin
      if (we) begin
        if (exp_q.size() == 0) chk("unexpected_we", 32'd1, 32'd0);
        else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("waddr", waddr, e[63:32]);
          chk("wdata", wdata, e[31:0]);
        end
        if (prev_we) chk("we_width", 32'd2, 32'd1);
        last_waddr = waddr;
      end
      prev_we = we;
    end else prev_we = 1'b0;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Offer one byte after 'gap' idle cycles; byte_ready must be high throughout.
  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int g = 0; g < gap; g++) begin
      byte_valid = 1'b0;
      @(negedge clock);
      chk("ready_gap", {31'd0, byte_ready}, 32'd1);
      @(posedge clock); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clock);
    chk("ready", {31'd0, byte_ready}, 32'd1);
    @(posedge clock); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], (maxgap == 0) ? 0 : $urandom_range(0, maxgap));
  endtask

  task automatic wait_level(input string name, input bit want_err);
    int k;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!(want_err ? error : done) && k < 50);
    chk(name, {31'd0, (want_err ? error : done)}, 32'd1);
    @(posedge clock); #1;
  endtask

  // Idle-side check: byte_valid offered while the loader is not ready.
  task automatic poke_idle(input int cycles);
    byte_valid = 1'b1;
    byte_data  = 8'hEE;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clock);
      chk("ready_low", {31'd0, byte_ready}, 32'd0);
      @(posedge clock); #1;
    end
    byte_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] img[2];
    img[0] = 32'h00000013;
    img[1] = 32'h00100093;
    reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", {31'd0, byte_ready}, 32'd0);
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_waddr", waddr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;

    // 1: two-word image, continuous stream
    pulse_start();
    exp_q.push_back({32'd0, img[0]});
    exp_q.push_back({32'd4, img[1]});
    send_word(32'd2, 0);
    send_word(img[0], 0);
    send_word(img[1], 0);
    wait_level("t1_done", 1'b0);
    chk("t1_hold", {31'd0, cpu_hold}, 32'd0);
    chk("t1_ready", {31'd0, byte_ready}, 32'd0);
    chk("t1_sb", exp_q.size(), 32'd0);

    // 2: same image with random gaps between bytes
    pulse_start();
    exp_q.push_back({32'd0, img[0]});
    exp_q.push_back({32'd4, img[1]});
    send_word(32'd2, 3);
    send_word(img[0], 3);
    send_word(img[1], 3);
    wait_level("t2_done", 1'b0);
    chk("t2_sb", exp_q.size(), 32'd0);

    // 3: oversize length -> ERROR, then empty image -> DONE
    pulse_start();
    send_word(32'd2049, 0);
    wait_level("t3_error", 1'b1);
    chk("t3_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t3_done", {31'd0, done}, 32'd0);
    poke_idle(2);
    pulse_start();
    send_word(32'd0, 0);
    wait_level("t3_done0", 1'b0);
    chk("t3_err_clr", {31'd0, error}, 32'd0);

    // 4: N == DEPTH, incrementing pattern
    pulse_start();
    send_word(32'd2048, 0);
    for (int k = 0; k < 2048; k++) begin
      exp_q.push_back({32'(k) << 2, 32'(k)});
      send_word(32'(k), 0);
    end
    wait_level("t4_done", 1'b0);
    chk("t4_last", last_waddr, 32'h00001FFC);
    chk("t4_sb", exp_q.size(), 32'd0);

    // 5: reset after 6 image bytes, then full reload from address 0
    pulse_start();
    exp_q.push_back({32'd0, img[0]});
    send_word(32'd2, 0);
    send_word(img[0], 0);
    send_byte(img[1][7:0], 0);
    send_byte(img[1][15:8], 0);
    reset = 1'b1;
    @(negedge clock);
    chk("t5_we", {31'd0, we}, 32'd0);
    chk("t5_hold", {31'd0, cpu_hold}, 32'd1);
    chk("t5_ready", {31'd0, byte_ready}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    chk("t5_sb", exp_q.size(), 32'd0);
    pulse_start();
    exp_q.push_back({32'd0, img[0]});
    exp_q.push_back({32'd4, img[1]});
    send_word(32'd2, 0);
    send_word(img[0], 0);
    send_word(img[1], 0);
    wait_level("t5_done2", 1'b0);

    // 6: byte_valid in DONE, start during DATA, then restart
    poke_idle(3);
    chk("t6_done_held", {31'd0, done}, 32'd1);
    pulse_start();
    @(negedge clock);
    chk("t6_done_clr", {31'd0, done}, 32'd0);
    @(posedge clock); #1;
    exp_q.push_back({32'd0, 32'hCAFEF00D});
    send_word(32'd1, 0);
    send_byte(8'h0D, 0);
    send_byte(8'hF0, 0);
    pulse_start();
    send_byte(8'hFE, 0);
    send_byte(8'hCA, 0);
    wait_level("t6_done", 1'b0);
    chk("t6_sb", exp_q.size(), 32'd0);

    repeat (3) @(posedge clock);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
